// File: rtl/serial_word_receiver_if.sv
// Serial link bundle for serial_word_receiver: serial line in, recovered words and status out.
// master = link driver / consumer side, slave = receiver.
interface serial_word_receiver_if #(
    parameter int WORD_W = 4
);
    logic              S_in;
    logic [WORD_W-1:0] A_out;
    logic [WORD_W-1:0] B_out;
    logic [WORD_W-1:0] C_out;
    logic [WORD_W-1:0] D_out;
    logic              done;
    logic              busy;
    logic              frame_err;

    modport master (
        output S_in,
        input  A_out, B_out, C_out, D_out, done, busy, frame_err
    );

    modport slave (
        input  S_in,
        output A_out, B_out, C_out, D_out, done, busy, frame_err
    );
endinterface

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel frame receiver: start 0, N_WORDS*WORD_W data bits LSB first, stop 1.
// Define SERIAL_RX_PARITY_EN to expect an even-parity bit between the data bits and the stop bit.
module serial_word_receiver #(
    parameter int WORD_W  = 4,
    parameter int N_WORDS = 4
) (
    input logic                  clock,
    input logic                  clr,
    serial_word_receiver_if.slave bus
);
    localparam int FRAME_BITS = WORD_W * N_WORDS;

    typedef enum logic [2:0] {
        IDLE,
        DATA,
`ifdef SERIAL_RX_PARITY_EN
        PAR,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t                  state;
    logic [FRAME_BITS-1:0]   shift_reg;
    logic [4:0]              bit_cnt;
`ifdef SERIAL_RX_PARITY_EN
    logic                    parity_ok;
`endif

    always_ff @(posedge clock) begin
        if (clr) begin
            state         <= IDLE;
            shift_reg     <= '0;
            bit_cnt       <= '0;
`ifdef SERIAL_RX_PARITY_EN
            parity_ok     <= 1'b0;
`endif
            bus.A_out     <= '0;
            bus.B_out     <= '0;
            bus.C_out     <= '0;
            bus.D_out     <= '0;
            bus.done      <= 1'b0;
            bus.busy      <= 1'b0;
            bus.frame_err <= 1'b0;
        end else begin
            bus.done      <= 1'b0;
            bus.frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.S_in) begin
                        state    <= DATA;
                        bit_cnt  <= '0;
                        bus.busy <= 1'b1;
                    end
                end
                DATA: begin
                    // Shift right so the first received bit ends up at bit 0 (word A, LSB).
                    shift_reg <= {bus.S_in, shift_reg[FRAME_BITS-1:1]};
                    bit_cnt   <= bit_cnt + 5'd1;
                    if (bit_cnt == 5'(FRAME_BITS - 1)) begin
`ifdef SERIAL_RX_PARITY_EN
                        state <= PAR;
`else
                        state <= STOP;
`endif
                    end
                end
`ifdef SERIAL_RX_PARITY_EN
                PAR: begin
                    parity_ok <= ~(^{shift_reg, bus.S_in});
                    state     <= STOP;
                end
`endif
                STOP: begin
                    if (!bus.S_in) begin
                        // Line still low: hold off start detection until it returns high.
                        bus.frame_err <= 1'b1;
                        state         <= WAIT_IDLE;
                    end
`ifdef SERIAL_RX_PARITY_EN
                    else if (!parity_ok) begin
                        bus.frame_err <= 1'b1;
                        bus.busy      <= 1'b0;
                        state         <= IDLE;
                    end
`endif
                    else begin
                        bus.A_out <= shift_reg[0*WORD_W +: WORD_W];
                        bus.B_out <= shift_reg[1*WORD_W +: WORD_W];
                        bus.C_out <= shift_reg[2*WORD_W +: WORD_W];
                        bus.D_out <= shift_reg[3*WORD_W +: WORD_W];
                        bus.done  <= 1'b1;
                        bus.busy  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WAIT_IDLE: begin
                    if (bus.S_in) begin
                        bus.busy <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: begin
                    bus.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_word_receiver.sv
// Randomized self-checking bench for serial_word_receiver; expected per-cycle outputs are
// generated from frame-level rules while the line stimulus is composed.
module tb_serial_word_receiver;
    logic clock = 1'b0;
    logic clr   = 1'b1;

    always #5 clock = ~clock;

    serial_word_receiver_if #(.WORD_W(4)) bus ();

    serial_word_receiver #(.WORD_W(4), .N_WORDS(4)) dut (
        .clock (clock),
        .clr   (clr),
        .bus   (bus)
    );

    // One row per clock edge: line/reset driven before the edge, outputs required after it.
    typedef struct {
        logic        s;
        logic        clr;
        logic        done;
        logic        err;
        logic        busy;
        logic [15:0] outw;
    } row_t;

    row_t         rows[$];
    logic [15:0]  cur_out;
    int unsigned  n_cmp = 0;
    int unsigned  n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic push_row(input logic s, input logic c, input logic d, input logic e, input logic b);
        row_t r;
        r.s    = s;
        r.clr  = c;
        r.done = d;
        r.err  = e;
        r.busy = b;
        r.outw = cur_out;
        rows.push_back(r);
    endtask

    task automatic push_idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) push_row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // data = {D,C,B,A}; sent as bit 0 first.
    task automatic push_frame(input logic [15:0] data, input bit stop_ok,
                              input int unsigned low_len, input bit par_bad);
        push_row(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 16; i++) push_row(data[i], 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef SERIAL_RX_PARITY_EN
        push_row((^data) ^ par_bad, 1'b0, 1'b0, 1'b0, 1'b1);
`endif
        if (!stop_ok) begin
            push_row(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            for (int unsigned i = 0; i < low_len; i++) push_row(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
            push_row(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        end else if (par_bad) begin
            push_row(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        end else begin
            cur_out = data;
            push_row(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        end
    endtask

    task automatic push_abort(input logic [15:0] data, input int unsigned nbits);
        push_row(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int unsigned i = 0; i < nbits; i++) push_row(data[i], 1'b0, 1'b0, 1'b0, 1'b1);
        cur_out = '0;
        push_row(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        row_t        r;
        int unsigned sel;
        logic [15:0] w;

        cur_out = '0;
        push_row(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_row(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push_idle(3);
        push_frame(16'hF5A3, 1'b1, 0, 1'b0);          // A=3 B=A C=5 D=F
        push_idle(2);
        push_frame(16'h1234, 1'b0, 5, 1'b0);          // bad stop, line low 5 more cycles
        push_idle(2);
        push_frame(16'h4321, 1'b1, 0, 1'b0);          // (1,2,3,4)
        push_frame(16'hCDEF, 1'b1, 0, 1'b0);          // (F,E,D,C) back-to-back
        push_idle(1);
        push_frame(16'h4321, 1'b1, 0, 1'b0);
        push_abort(16'h9999, 7);
        push_frame(16'h8765, 1'b1, 0, 1'b0);
        push_idle(100);
`ifdef SERIAL_RX_PARITY_EN
        push_frame(16'hF5A3, 1'b1, 0, 1'b0);
        push_frame(16'hF5A3, 1'b1, 0, 1'b1);
`endif

        repeat (40) begin
            sel = $urandom_range(0, 9);
            w   = 16'($urandom);
            case (sel)
                0, 1, 2, 3, 4: begin
                    push_idle($urandom_range(0, 3));
                    push_frame(w, 1'b1, 0, 1'b0);
                end
                5, 6:    push_frame(w, 1'b0, $urandom_range(0, 6), 1'b0);
                7:       push_abort(w, $urandom_range(0, 15));
                8:       push_idle($urandom_range(1, 20));
                default: begin
`ifdef SERIAL_RX_PARITY_EN
                    push_frame(w, 1'b1, 0, 1'b1);
`else
                    push_frame(w, 1'b1, 0, 1'b0);
`endif
                end
            endcase
        end
        push_idle(4);

        while (rows.size() > 0) begin
            r = rows.pop_front();
            bus.S_in = r.s;
            clr      = r.clr;
            @(posedge clock);
            #1;
            check("done",      32'(bus.done),      32'(r.done));
            check("frame_err", 32'(bus.frame_err), 32'(r.err));
            check("busy",      32'(bus.busy),      32'(r.busy));
            check("words_DCBA", 32'({bus.D_out, bus.C_out, bus.B_out, bus.A_out}), 32'(r.outw));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
